frame_deframer: RTL and testbench
=================================

// Module: frame_deframer
// PURPOSE
//  Receive-side counterpart of the framing transmitter. Takes a serial bitstream (LSB-first),
//  locks on the alternating preamble, aligns on the 16-bit SFD, then deserialises the payload
//  into bytes. Ends the frame when the serial valid drops. Sits between the line sampler and
//  the receive byte FIFO.
// PARAMETERS
//  PRE_MIN     32        consecutive alternating bits required to qualify a preamble
//  SFD         16'hF398  start-frame delimiter, compared in LSB-first arrival order
//  SFD_TIMEOUT 64        max valid bits after preamble qualification before SFD must match
//  DATA_W      8         payload word width (bits per output byte)
//  CNT_W       16        width of the frame byte counter
// PORTS
//  clk            in   1       rising-edge clock; all inputs sampled on posedge
//  rst            in   1       synchronous reset, active-high
//  data_in        in   1       serial line bit
//  data_in_valid  in   1       data_in qualifier; low while in PAYLOAD = end of frame
//  data_out       out  DATA_W  deserialised byte; bit 0 = first bit received
//  data_out_valid out  1       one-cycle strobe, data_out valid
//  frame_active   out  1       high in PAYLOAD state
//  frame_done     out  1       one-cycle strobe at end of frame
//  frame_err      out  1       one-cycle strobe with frame_done if a partial byte was discarded
//  sfd_err        out  1       one-cycle strobe on SFD timeout
//  byte_cnt       out  CNT_W   bytes in current/last frame; held after frame_done
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=HUNT; all outputs 0; data_out=0, byte_cnt=0; shift reg,
//   counters cleared. rst has priority over everything, including mid-frame.
//  Only posedges with data_in_valid=1 advance bit-level logic. All bits shift into
//   sr[15:0] as sr <= {data_in, sr[15:1]}, in every state.
//  HUNT: pre_cnt=1 on first valid bit; pre_cnt+1 if data_in != previous bit, else pre_cnt=1.
//   pre_cnt==PRE_MIN -> SYNC, sfd_tmr=0. data_in_valid=0 -> pre_cnt=0.
//  SYNC: each valid bit sfd_tmr+1. Shifted value == SFD -> PAYLOAD, bit_cnt=0, byte_cnt=0
//   (match judged on the register value including the current bit).
//   sfd_tmr reaches SFD_TIMEOUT without match -> sfd_err strobe, HUNT.
//   data_in_valid=0 -> HUNT, no strobes.
//  PAYLOAD: valid bit stored at position bit_cnt; bit_cnt+1. On DATA_W-th bit, same posedge:
//   data_out <= assembled byte, data_out_valid=1 for one cycle, bit_cnt=0,
//   byte_cnt+1 (saturates at all-ones). Latency: strobe visible the cycle after last-bit edge.
//   data_in_valid=0 -> frame_done strobe; frame_err=1 iff bit_cnt!=0 (partial byte dropped);
//   -> HUNT. frame_done occurs with no data_out_valid on the same edge.
//  frame_active = (state==PAYLOAD), registered.
//  Back-to-back frames: one invalid cycle is sufficient to end the frame; hunt restarts on
//   the next valid bit.
//  Zero-byte frame (valid drops right after SFD): frame_done=1, frame_err=0, byte_cnt=0.
//  No backpressure: downstream consumes every strobe; strobes at most 1 per DATA_W valid bits.
// TESTING
//  T1: 64b preamble (0xAA x8 LSB-first) + SFD + 0xA5,0x3C, valid drop -> data_out A5 then 3C,
//      frame_done=1, frame_err=0, byte_cnt=2.
//  T2: 16 alternating bits, SFD, 0xFF -> never leaves HUNT; no data_out_valid, no frame_done.
//  T3: 64b preamble + SFD=16'hF399 + 48 more alternating bits -> sfd_err one cycle at 64th bit
//      after qualification; state HUNT.
//  T4: valid frame, payload 0x55 + 3 bits, valid drop -> one byte 0x55; frame_done+frame_err,
//      byte_cnt=1.
//  T5: rst pulsed after 4 payload bits -> next cycle all outputs 0, state HUNT; following full
//      frame with 0x81 received correctly.
//  T6: two frames (0x12 / 0x34,0x56) separated by one invalid cycle -> two frame_done strobes,
//      byte_cnt 1 then 2, bytes in order.

Source files
------------

// File: rtl/frame_deframer.sv
// Receive deframer: qualifies an alternating preamble, aligns on the SFD and
// deserialises the LSB-first payload into DATA_W-bit words until valid drops.
module frame_deframer #(
  parameter int          PRE_MIN     = 32,
  parameter logic [15:0] SFD         = 16'hF398,
  parameter int          SFD_TIMEOUT = 64,
  parameter int          DATA_W      = 8,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              frame_active,
  output logic              frame_done,
  output logic              frame_err,
  output logic              sfd_err,
  output logic [CNT_W-1:0]  byte_cnt
);
  localparam int PW = $clog2(PRE_MIN + 1);
  localparam int TW = $clog2(SFD_TIMEOUT + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {HUNT, SYNC, PAYLOAD} state_t;

  state_t            state, state_n;
  logic [15:0]       sr, sr_n, sr_sh;
  logic [PW-1:0]     pre_cnt, pre_cnt_n;
  logic [TW-1:0]     sfd_tmr, sfd_tmr_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] data_out_n;
  logic              dov_n, done_n, ferr_n, serr_n;
  logic [CNT_W-1:0]  byte_cnt_n;

  assign sr_sh        = {data_in, sr[15:1]};
  assign frame_active = (state == PAYLOAD);

  always_comb begin
    state_n    = state;
    sr_n       = sr;
    pre_cnt_n  = pre_cnt;
    sfd_tmr_n  = sfd_tmr;
    bit_cnt_n  = bit_cnt;
    data_out_n = data_out;
    byte_cnt_n = byte_cnt;
    dov_n      = 1'b0;
    done_n     = 1'b0;
    ferr_n     = 1'b0;
    serr_n     = 1'b0;
    if (data_in_valid) sr_n = sr_sh;
    case (state)
      HUNT: begin
        if (!data_in_valid) begin
          pre_cnt_n = '0;
        end else begin
          // pre_cnt==0 means no previous bit in this run, so any bit starts a new one
          if (pre_cnt != '0 && data_in != sr[15]) pre_cnt_n = pre_cnt + PW'(1);
          else                                    pre_cnt_n = PW'(1);
          if (pre_cnt_n == PW'(PRE_MIN)) begin
            state_n   = SYNC;
            sfd_tmr_n = '0;
            pre_cnt_n = '0;
          end
        end
      end
      SYNC: begin
        if (!data_in_valid) begin
          state_n = HUNT;
        end else begin
          sfd_tmr_n = sfd_tmr + TW'(1);
          if (sr_sh == SFD) begin
            state_n    = PAYLOAD;
            bit_cnt_n  = '0;
            byte_cnt_n = '0;
          end else if (sfd_tmr_n == TW'(SFD_TIMEOUT)) begin
            serr_n  = 1'b1;
            state_n = HUNT;
          end
        end
      end
      PAYLOAD: begin
        if (!data_in_valid) begin
          done_n  = 1'b1;
          ferr_n  = (bit_cnt != '0);
          state_n = HUNT;
        end else if (bit_cnt == BW'(DATA_W - 1)) begin
          // the last DATA_W arrivals sit at the top of sr, first bit lowest
          data_out_n = sr_sh[15 -: DATA_W];
          dov_n      = 1'b1;
          bit_cnt_n  = '0;
          if (byte_cnt != '1) byte_cnt_n = byte_cnt + CNT_W'(1);
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      sr             <= '0;
      pre_cnt        <= '0;
      sfd_tmr        <= '0;
      bit_cnt        <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      sfd_err        <= 1'b0;
      byte_cnt       <= '0;
    end else begin
      state          <= state_n;
      sr             <= sr_n;
      pre_cnt        <= pre_cnt_n;
      sfd_tmr        <= sfd_tmr_n;
      bit_cnt        <= bit_cnt_n;
      data_out       <= data_out_n;
      data_out_valid <= dov_n;
      frame_done     <= done_n;
      frame_err      <= ferr_n;
      sfd_err        <= serr_n;
      byte_cnt       <= byte_cnt_n;
    end
  end
endmodule

// File: tb/tb_frame_deframer.sv
// Directed bench for frame_deframer: preamble/SFD/payload sequences with
// hand-computed bytes, strobes and counts.
module tb_frame_deframer;
  logic        clk = 1'b0;
  logic        rst, data_in, data_in_valid;
  logic [7:0]  data_out;
  logic        data_out_valid, frame_active, frame_done, frame_err, sfd_err;
  logic [15:0] byte_cnt;

  int checks = 0, failures = 0;
  int n_dov = 0, n_done = 0, n_ferr = 0, n_serr = 0, n_act = 0;
  logic [7:0] got [$];

  frame_deframer dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_out(data_out), .data_out_valid(data_out_valid), .frame_active(frame_active),
    .frame_done(frame_done), .frame_err(frame_err), .sfd_err(sfd_err), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_out_valid) begin n_dov++; got.push_back(data_out); end
    if (frame_done) n_done++;
    if (frame_err)  n_ferr++;
    if (sfd_err)    n_serr++;
    if (frame_active) n_act++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_dov = 0; n_done = 0; n_ferr = 0; n_serr = 0; n_act = 0;
    got.delete();
  endtask

  task automatic bit_(input logic b);
    data_in = b; data_in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    data_in = 1'b0; data_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pre(input int n);
    for (int i = 0; i < n; i++) bit_(i[0]);
  endtask

  task automatic word(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) bit_(v[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1; data_in = 1'b0; data_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_dout", data_out, 0);
    chk("rst_dov", data_out_valid, 0);
    chk("rst_act", frame_active, 0);
    chk("rst_done", {frame_done, frame_err, sfd_err}, 0);
    chk("rst_bcnt", byte_cnt, 0);

    // T1: basic two-byte frame
    clr();
    pre(64); word(16'hF398, 16);
    chk("t1_active", frame_active, 1);
    word(16'h00A5, 8);
    chk("t1_b0", data_out, 8'hA5);
    chk("t1_b0v", data_out_valid, 1);
    word(16'h003C, 8);
    chk("t1_b1", data_out, 8'h3C);
    chk("t1_bcnt", byte_cnt, 2);
    idle();
    chk("t1_done", frame_done, 1);
    chk("t1_err", frame_err, 0);
    chk("t1_dov_at_done", data_out_valid, 0);
    chk("t1_act_off", frame_active, 0);
    chk("t1_bcnt_hold", byte_cnt, 2);
    chk("t1_nbytes", got.size(), 2);
    if (got.size() == 2) begin
      chk("t1_q0", got[0], 8'hA5);
      chk("t1_q1", got[1], 8'h3C);
    end
    idle();
    chk("t1_done_1cyc", frame_done, 0);

    // T2: short preamble never qualifies
    clr();
    pre(16); word(16'hF398, 16); word(16'h00FF, 8); idle(); idle();
    chk("t2_dov", n_dov, 0);
    chk("t2_done", n_done, 0);
    chk("t2_act", n_act, 0);

    // T3: wrong SFD -> timeout at 64th bit after qualification
    clr();
    pre(64); word(16'hF399, 16);
    pre(15);
    chk("t3_serr_early", n_serr, 0);
    bit_(1'b1);
    chk("t3_serr", sfd_err, 1);
    chk("t3_act", frame_active, 0);
    bit_(1'b0);
    chk("t3_serr_1cyc", sfd_err, 0);
    pre(31); idle(); idle();
    chk("t3_serr_cnt", n_serr, 1);
    chk("t3_nodone", n_done + n_dov, 0);

    // T4: one byte plus three dangling bits
    clr();
    pre(64); word(16'hF398, 16); word(16'h0055, 8); word(16'h0005, 3);
    idle();
    chk("t4_done", frame_done, 1);
    chk("t4_err", frame_err, 1);
    chk("t4_bcnt", byte_cnt, 1);
    chk("t4_nbytes", got.size(), 1);
    if (got.size() == 1) chk("t4_q0", got[0], 8'h55);
    idle();

    // T5: reset mid-frame, then a clean frame
    clr();
    pre(64); word(16'hF398, 16); word(16'h007E, 8); word(16'h000F, 4);
    chk("t5_pre_bcnt", byte_cnt, 1);
    do_reset();
    chk("t5_dout", data_out, 0);
    chk("t5_bcnt", byte_cnt, 0);
    chk("t5_act", frame_active, 0);
    chk("t5_strobes", {data_out_valid, frame_done, frame_err, sfd_err}, 0);
    clr();
    pre(64); word(16'hF398, 16); word(16'h0081, 8); idle();
    chk("t5_done", {frame_done, frame_err}, 2'b10);
    chk("t5_bcnt2", byte_cnt, 1);
    chk("t5_nbytes", got.size(), 1);
    if (got.size() == 1) chk("t5_q0", got[0], 8'h81);

    // T6: back-to-back frames with a single invalid gap
    clr();
    pre(64); word(16'hF398, 16); word(16'h0012, 8); idle();
    chk("t6_done1", frame_done, 1);
    chk("t6_bcnt1", byte_cnt, 1);
    pre(64); word(16'hF398, 16); word(16'h0034, 8); word(16'h0056, 8); idle();
    chk("t6_done2", {frame_done, frame_err}, 2'b10);
    chk("t6_bcnt2", byte_cnt, 2);
    chk("t6_ndone", n_done, 2);
    chk("t6_nbytes", got.size(), 3);
    if (got.size() == 3) begin
      chk("t6_q0", got[0], 8'h12);
      chk("t6_q1", got[1], 8'h34);
      chk("t6_q2", got[2], 8'h56);
    end

    // zero-byte frame
    clr();
    pre(64); word(16'hF398, 16); idle();
    chk("t7_done", {frame_done, frame_err}, 2'b10);
    chk("t7_bcnt", byte_cnt, 0);
    chk("t7_dov", n_dov, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
